l2_port_arbiter: RTL

- Shares the single next-level (L2) line port between the instruction cache and the data cache.
- Accepts line-fill requests from the I-cache and line-fill/write-back requests from the D-cache, grants one at a time, and sequences the L2 request/acknowledge handshake.
- Returns the 512-bit line to the winning requester.
- Sits between the two L1 caches and the L2 model in the top-level wrapper; also exports a tie counter to the stats block.

---
 rtl/l2_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Shares the single L2 line port between the I-cache and the D-cache.
//   One request is granted at a time; the arbiter drives the L2
//   request/acknowledge handshake and returns the line to the winner.
//
// Handshake contract (all interfaces):
//   A requester raises *_req with stable address/qualifiers and holds it
//   until its one-cycle *_ack pulse, then drops *_req in the following
//   cycle. Toward L2, l2_req is held with stable l2_add/l2_we/l2_wdata
//   until a one-cycle l2_ack (with l2_rdata) or until the wait budget of
//   TIMEOUT cycles runs out. An l2_ack outside WAIT is ignored.
//
// Ports:
//   clk, clear            clock, synchronous active-low reset
//   i_req/i_add           I-cache fill request and line address
//   i_ack/i_data          I-cache completion pulse and returned line
//   d_req/d_we/d_add/d_wdata  D-cache fill (we=0) or write-back (we=1)
//   d_ack/d_rdata         D-cache completion pulse and returned line
//   l2_req/l2_we/l2_add/l2_wdata  request to L2
//   l2_ack/l2_rdata       L2 completion pulse and read line
//   err                   pulses with the ack of a timed-out transaction
//   busy                  high whenever the FSM is not in IDLE
//   ties                  count of IDLE samples with both requests high
module l2_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 512,
    parameter int D_PRIORITY = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_add,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_add,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_add,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_ack,
    input  logic [LINE_W-1:0] l2_rdata,
    output logic              err,
    output logic              busy,
    output logic [31:0]       ties
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last wait cycle before the budget is exhausted.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_d;    // round-robin pointer: 1 = D was granted last
    logic        gnt_d;     // current grant belongs to the D-cache
    logic [15:0] wait_cnt;
    logic        pick_d;

    // Winner of the current IDLE sample. On a tie the requester that was
    // not granted last wins, unless the D-cache has fixed priority.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req) begin
            pick_d = (D_PRIORITY != 0) ? 1'b1 : !last_d;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!clear) begin
            state    <= IDLE;
            last_d   <= 1'b1;
            gnt_d    <= 1'b0;
            wait_cnt <= '0;
            i_ack    <= 1'b0;
            i_data   <= '0;
            d_ack    <= 1'b0;
            d_rdata  <= '0;
            l2_req   <= 1'b0;
            l2_we    <= 1'b0;
            l2_add   <= '0;
            l2_wdata <= '0;
            err      <= 1'b0;
            ties     <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (i_req && d_req) begin
                            ties <= ties + 32'd1;
                        end
                        gnt_d    <= pick_d;
                        last_d   <= pick_d;
                        l2_req   <= 1'b1;
                        l2_add   <= pick_d ? d_add : i_add;
                        l2_we    <= pick_d & d_we;
                        l2_wdata <= pick_d ? d_wdata : '0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack on the last budget cycle still counts as success.
                    if (l2_ack) begin
                        l2_req <= 1'b0;
                        if (gnt_d) begin
                            if (!l2_we) begin
                                d_rdata <= l2_rdata;
                            end
                            d_ack <= 1'b1;
                        end else begin
                            i_data <= l2_rdata;
                            i_ack  <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Abort: no data captured, requester acked with err.
                        l2_req   <= 1'b0;
                        err      <= 1'b1;
                        d_ack    <= gnt_d;
                        i_ack    <= !gnt_d;
                        wait_cnt <= wait_cnt + 16'd1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    // Requests are not sampled here; the acked requester
                    // drops its request before the next IDLE sample.
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
